// File: rtl/stopwatch_ctrl_if.sv
// Button-to-controller and controller-to-datapath signal bundle for the stopwatch.
// master = the control FSM, slave = debouncer/counter/display side.
interface stopwatch_ctrl_if;
  logic [2:0] BTN;
  logic       CNT_EN;
  logic       CNT_CLR;
  logic       DISP_HOLD;
  logic [1:0] STATE;

  modport master (
    input  BTN,
    output CNT_EN,
    output CNT_CLR,
    output DISP_HOLD,
    output STATE
  );

  modport slave (
    output BTN,
    input  CNT_EN,
    input  CNT_CLR,
    input  DISP_HOLD,
    input  STATE
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced button pulses into run/stop/lap/clear
// sequencing, and divides CLK down to the counter tick enable.
module stopwatch_ctrl #(
  parameter int DIV  = 500000,
  parameter int DIVW = 19
) (
  input  logic              CLK,
  input  logic              RST,
  stopwatch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10,
    ST_LAP  = 2'b11
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              clear_next;
  logic [DIVW-1:0]   presc_reg;
  logic              cnt_en_reg;
  logic              cnt_clr_reg;
  logic              disp_hold_reg;

  logic              counting;
  logic              wrap;

  // Time advances in RUN and LAP alike; the decision uses the pre-transition state.
  assign counting = (state_reg == ST_RUN) || (state_reg == ST_LAP);
  assign wrap     = (presc_reg == DIVW'(DIV - 1));

  // Button decode: BTN[2] beats BTN[0] beats BTN[1]; losers are simply dropped.
  always_comb begin
    state_next = state_reg;
    clear_next = 1'b0;
    if (bus.BTN[2]) begin
      state_next = ST_IDLE;
      clear_next = 1'b1;
    end else if (bus.BTN[0]) begin
      case (state_reg)
        ST_IDLE: state_next = ST_RUN;
        ST_RUN:  state_next = ST_STOP;
        ST_LAP:  state_next = ST_STOP;
        ST_STOP: state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end else if (bus.BTN[1]) begin
      case (state_reg)
        ST_RUN:  state_next = ST_LAP;
        ST_LAP:  state_next = ST_RUN;
        ST_STOP: begin
          state_next = ST_IDLE;
          clear_next = 1'b1;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      presc_reg     <= '0;
      cnt_en_reg    <= 1'b0;
      cnt_clr_reg   <= 1'b0;
      disp_hold_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      disp_hold_reg <= (state_next == ST_LAP);
      cnt_clr_reg   <= clear_next;
      cnt_en_reg    <= counting && wrap;

      // A clearing transition restarts the period; STOP simply holds the partial count.
      if (state_next == ST_IDLE) begin
        presc_reg <= '0;
      end else if (counting) begin
        presc_reg <= wrap ? '0 : presc_reg + DIVW'(1);
      end
    end
  end

  assign bus.STATE     = state_reg;
  assign bus.CNT_EN    = cnt_en_reg;
  assign bus.CNT_CLR   = cnt_clr_reg;
  assign bus.DISP_HOLD = disp_hold_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (DIV=4): per-cycle expectations queued at
// drive time, popped and checked one clock later, plus explicit tick-timing checks.
module tb_stopwatch_ctrl;
  localparam int DIV  = 4;
  localparam int DIVW = 2;

  typedef struct packed {
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       hold;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.DIV(DIV), .DIVW(DIVW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (sw_if.master)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_step = 0;

  // Reference model: state plus number of ticking cycles accumulated since the last tick.
  logic [1:0] m_state = 2'b00;
  int         m_acc   = 0;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, n_step, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, predict the registered outputs, then compare after the edge.
  task automatic step(input logic [2:0] btn, input logic rst);
    exp_t e;
    logic [1:0] nxt;
    logic       clr;
    sw_if.BTN = btn;
    RST       = rst;
    e   = '0;
    nxt = m_state;
    clr = 1'b0;
    if (rst) begin
      m_state = 2'b00;
      m_acc   = 0;
    end else begin
      if (m_state == 2'b01 || m_state == 2'b11) begin
        m_acc++;
        if (m_acc == DIV) begin
          m_acc = 0;
          e.en  = 1'b1;
        end
      end
      if (btn[2]) begin
        nxt = 2'b00; clr = 1'b1;
      end else if (btn[0]) begin
        nxt = (m_state == 2'b00 || m_state == 2'b10) ? 2'b01 : 2'b10;
      end else if (btn[1]) begin
        if (m_state == 2'b01)      nxt = 2'b11;
        else if (m_state == 2'b11) nxt = 2'b01;
        else if (m_state == 2'b10) begin nxt = 2'b00; clr = 1'b1; end
      end
      if (nxt == 2'b00) m_acc = 0;
      m_state = nxt;
    end
    e.st   = m_state;
    e.clr  = clr;
    e.hold = (m_state == 2'b11);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    n_step++;
    e = exp_q.pop_front();
    check("STATE",     sw_if.STATE,            e.st);
    check("CNT_EN",    {1'b0, sw_if.CNT_EN},    {1'b0, e.en});
    check("CNT_CLR",   {1'b0, sw_if.CNT_CLR},   {1'b0, e.clr});
    check("DISP_HOLD", {1'b0, sw_if.DISP_HOLD}, {1'b0, e.hold});
    $display("step %0d btn=%b rst=%b state=%b en=%b clr=%b hold=%b",
             n_step, btn, rst, sw_if.STATE, sw_if.CNT_EN, sw_if.CNT_CLR, sw_if.DISP_HOLD);
    sw_if.BTN = 3'b000;
    RST       = 1'b0;
  endtask

  initial begin
    sw_if.BTN = 3'b000;
    @(posedge CLK);
    #1;

    // 1: reset, then LAP/RESET in IDLE is ignored
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);
    step(3'b010, 1'b0);
    step(3'b000, 1'b0);

    // 2: start at edge k; ticks at k+4, k+8, k+12
    step(3'b001, 1'b0);
    check("RUN_ENTRY", sw_if.STATE, 2'b01);
    for (int i = 1; i <= 12; i++) begin
      step(3'b000, 1'b0);
      check("TICK_K", {1'b0, sw_if.CNT_EN}, {1'b0, (i % 4 == 0)});
    end

    // 3: stop with prescaler at 2, no ticks while stopped, resume finishes the period
    step(3'b000, 1'b0);
    step(3'b001, 1'b0);
    check("STOP_ENTRY", sw_if.STATE, 2'b10);
    for (int i = 0; i < 20; i++) begin
      step(3'b000, 1'b0);
      check("STOP_NOTICK", {1'b0, sw_if.CNT_EN}, 2'b00);
    end
    step(3'b001, 1'b0);
    check("RESUME_NOTICK", {1'b0, sw_if.CNT_EN}, 2'b00);
    step(3'b000, 1'b0);
    check("RESUME_R1", {1'b0, sw_if.CNT_EN}, 2'b00);
    step(3'b000, 1'b0);
    check("RESUME_R2", {1'b0, sw_if.CNT_EN}, 2'b01);

    // 4: lap view keeps time running
    step(3'b010, 1'b0);
    check("LAP_HOLD", {1'b0, sw_if.DISP_HOLD}, 2'b01);
    for (int i = 1; i <= 8; i++) begin
      step(3'b000, 1'b0);
      check("LAP_TICK", {1'b0, sw_if.CNT_EN}, {1'b0, (i % 4 == 3)});
    end
    step(3'b010, 1'b0);
    check("LAP_EXIT", sw_if.STATE, 2'b01);

    // 5: BTN[0] beats BTN[1] in STOP; then STOP + LAP/RESET clears
    step(3'b001, 1'b0);
    step(3'b011, 1'b0);
    check("PRIO_RUN", sw_if.STATE, 2'b01);
    step(3'b001, 1'b0);
    step(3'b010, 1'b0);
    check("STOP_CLR", {1'b0, sw_if.CNT_CLR}, 2'b01);
    step(3'b000, 1'b0);
    check("CLR_ONE", {1'b0, sw_if.CNT_CLR}, 2'b00);

    // 6: clear from LAP with all buttons, clear while idle, reset beats start
    step(3'b001, 1'b0);
    step(3'b000, 1'b0);
    step(3'b010, 1'b0);
    step(3'b111, 1'b0);
    check("LAP_CLR_ST", sw_if.STATE, 2'b00);
    step(3'b000, 1'b0);
    step(3'b100, 1'b0);
    step(3'b001, 1'b0);
    step(3'b000, 1'b0);
    step(3'b001, 1'b1);
    check("RST_WINS", sw_if.STATE, 2'b00);
    step(3'b000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
